// File: rtl/mult_add_recomposer.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One operation in flight; WL iteration cycles plus one DONE cycle per operation.
module mult_add_recomposer #(
  parameter int WL = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WL-1:0]     multiplicand,
  input  logic [WL-1:0]     multiplier,
  input  logic [WL-1:0]     addend,
  output logic              ready,
  output logic              done,
  output logic [2*WL-1:0]   product
);

  localparam int CW = (WL > 2) ? $clog2(WL) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WL-1:0]     a_q, a_d;
  logic [WL-1:0]     b_q, b_d;
  logic [2*WL-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WL-1:0]   product_q, product_d;

  logic [2*WL-1:0]   partial_term;
  logic [2*WL-1:0]   acc_step;

  // Shifted multiplicand is added only when the current multiplier bit is set.
  always_comb begin
    partial_term = '0;
    if (b_q[cnt_q]) begin
      partial_term = {{WL{1'b0}}, a_q} << cnt_q;
    end
    acc_step = acc_q + partial_term;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          acc_d   = {{WL{1'b0}}, addend};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        // All WL bits are always processed, even for a zero multiplier.
        if (cnt_q == LAST_BIT) begin
          product_d = acc_step;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status comes straight off the state register, so reset clears it without a clock.
  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_add_recomposer.sv
// Randomized and directed bench for mult_add_recomposer; reference is plain A*B+C arithmetic.
module tb_mult_add_recomposer;

  localparam int WL = 4;

  logic              CLK;
  logic              RST;
  logic              start;
  logic [WL-1:0]     multiplicand;
  logic [WL-1:0]     multiplier;
  logic [WL-1:0]     addend;
  logic              ready;
  logic              done;
  logic [2*WL-1:0]   product;

  int checks;
  int failures;
  int cyc;
  logic [2*WL-1:0] prev_product;

  mult_add_recomposer #(.WL(WL)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Continuous properties: done/ready exclusive, product only moves with done or reset.
  always @(negedge CLK) begin
    chk("excl", longint'(done && ready), 0);
    if (!RST && !done) chk("hold", longint'(product), longint'(prev_product));
    prev_product = product;
  end

  function automatic longint model(input int a, input int b, input int c);
    return longint'(a) * longint'(b) + longint'(c);
  endfunction

  // noise: 0 quiet, 1 random inputs/start while busy, 2 start=1 with A=3,B=3,C=0 while busy
  task automatic do_op(input int a, input int b, input int c, input int noise);
    longint exp_v;
    longint prev_v;
    int n;
    exp_v = model(a, b, c);
    chk("idle_ready", longint'(ready), 1);
    multiplicand = WL'(a);
    multiplier   = WL'(b);
    addend       = WL'(c);
    start        = 1'b1;
    prev_v       = longint'(product);
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 16) begin
      chk("busy_ready", longint'(ready), 0);
      chk("busy_prod", longint'(product), prev_v);
      if (noise == 1) begin
        start        = 1'($urandom_range(0, 1));
        multiplicand = WL'($urandom);
        multiplier   = WL'($urandom);
        addend       = WL'($urandom);
      end else if (noise == 2) begin
        start        = 1'b1;
        multiplicand = 4'd3;
        multiplier   = 4'd3;
        addend       = 4'd0;
      end
      @(posedge CLK); #1;
      n++;
    end
    chk("latency", n, WL);
    chk("done_ready", longint'(ready), 0);
    chk("product", longint'(product), exp_v);
    $display("op A=%0d B=%0d C=%0d -> product=%0d (exp %0d) latency=%0d", a, b, c, product, exp_v, n);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("post_ready", longint'(ready), 1);
    chk("post_done", longint'(done), 0);
    chk("post_prod", longint'(product), exp_v);
    if (noise != 0) begin
      @(posedge CLK); #1;
      chk("not_queued", longint'(ready), 1);
      chk("still_prod", longint'(product), exp_v);
    end
  endtask

  initial begin
    int last_done;
    int a_v [3];
    int b_v [3];
    int c_v [3];
    int n;
    checks = 0; failures = 0; cyc = 0; prev_product = '0;
    RST = 1'b1; start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    #1;
    chk("rst_ready", longint'(ready), 1);
    chk("rst_done", longint'(done), 0);
    chk("rst_prod", longint'(product), 0);
    #21 RST = 1'b0;
    @(posedge CLK); #1;

    do_op(2, 6, 1, 0);
    do_op(15, 15, 15, 0);
    do_op(15, 15, 0, 0);
    do_op(9, 0, 7, 0);
    do_op(0, 11, 0, 0);
    do_op(2, 6, 1, 2);

    // Asynchronous reset in the 2nd RUN cycle aborts the operation.
    multiplicand = 4'd2; multiplier = 4'd6; addend = 4'd1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    #2 RST = 1'b1;
    #1;
    chk("arst_prod", longint'(product), 0);
    chk("arst_ready", longint'(ready), 1);
    chk("arst_done", longint'(done), 0);
    $display("async reset mid-RUN: product=%0d ready=%0d done=%0d", product, ready, done);
    #3 RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      chk("arst_nodone", longint'(done), 0);
    end
    do_op(5, 5, 4, 0);

    // start held high across three operations with inputs changing between them.
    for (int k = 0; k < 3; k++) begin
      a_v[k] = int'($urandom_range(0, 15));
      b_v[k] = int'($urandom_range(0, 15));
      c_v[k] = int'($urandom_range(0, 15));
    end
    multiplicand = WL'(a_v[0]); multiplier = WL'(b_v[0]); addend = WL'(c_v[0]);
    start = 1'b1;
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done && n < 20) begin
        @(posedge CLK); #1;
        n++;
        if (!done && !ready) begin
          multiplicand = WL'($urandom); multiplier = WL'($urandom); addend = WL'($urandom);
        end
      end
      chk("hs_timeout", longint'(done), 1);
      chk("hs_product", longint'(product), model(a_v[k], b_v[k], c_v[k]));
      if (k > 0) chk("hs_spacing", cyc - last_done, WL + 2);
      $display("held-start op%0d A=%0d B=%0d C=%0d -> product=%0d cyc=%0d", k, a_v[k], b_v[k], c_v[k], product, cyc);
      last_done = cyc;
      if (k < 2) begin
        multiplicand = WL'(a_v[k+1]); multiplier = WL'(b_v[k+1]); addend = WL'(c_v[k+1]);
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 20; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
